// File: rtl/sd_sector_loader_if.sv
// sd_sector_loader_if: SD block command port and RAM write port used by the sector loader.
interface sd_sector_loader_if #(
    parameter int AddressWidth = 32
);
    logic [1:0]              sd_cmd_o;
    logic [31:0]             sd_sector_o;
    logic [7:0]              sd_data_i;
    logic                    sd_busy_i;
    logic [AddressWidth-1:0] mem_addr_o;
    logic [31:0]             mem_data_o;
    logic                    mem_valid_o;
    logic                    mem_ready_i;

    modport master (
        output sd_cmd_o, sd_sector_o, mem_addr_o, mem_data_o, mem_valid_o,
        input  sd_data_i, sd_busy_i, mem_ready_i
    );

    modport slave (
        input  sd_cmd_o, sd_sector_o, mem_addr_o, mem_data_o, mem_valid_o,
        output sd_data_i, sd_busy_i, mem_ready_i
    );
endinterface

// File: rtl/sd_sector_loader.sv
// sd_sector_loader: copies consecutive 512-byte SD sectors into word-addressed RAM,
// packing bytes little-endian into 32-bit words.
module sd_sector_loader #(
    parameter int AddressWidth = 32,
    parameter int CountWidth   = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start_i,
    input  logic [31:0]             sector_i,
    input  logic [CountWidth-1:0]   count_i,
    input  logic [AddressWidth-1:0] dest_addr_i,
    output logic                    busy_o,
    output logic                    done_o,
    sd_sector_loader_if.master      bus
);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_READ, COLLECT, WRITE, FINISH} state_t;

    state_t                state, next_state;
    logic [31:0]           sector;
    logic [CountWidth-1:0] remaining;
    logic [8:0]            byte_idx;
    logic                  first;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            sector          <= '0;
            remaining       <= '0;
            byte_idx        <= '0;
            first           <= 1'b0;
            busy_o          <= 1'b0;
            done_o          <= 1'b0;
            bus.mem_addr_o  <= '0;
            bus.mem_data_o  <= '0;
            bus.mem_valid_o <= 1'b0;
        end else begin
            state  <= next_state;
            done_o <= state == FINISH;
            case (state)
                IDLE: if (start_i) begin
                    sector         <= sector_i;
                    remaining      <= count_i;
                    bus.mem_addr_o <= dest_addr_i & ~AddressWidth'(3);
                    busy_o         <= 1'b1;
                end
                ISSUE: first <= 1'b1;
                // SD busy lags cmd 1 by a cycle, so the first WaitRead cycle is blind
                WAIT_READ: begin
                    first    <= 1'b0;
                    byte_idx <= '0;
                end
                COLLECT: begin
                    bus.mem_data_o[{byte_idx[1:0], 3'b000} +: 8] <= bus.sd_data_i;
                    byte_idx        <= byte_idx + 9'd1;
                    bus.mem_valid_o <= byte_idx[1:0] == 2'd3;
                end
                WRITE: if (bus.mem_ready_i) begin
                    bus.mem_valid_o <= 1'b0;
                    bus.mem_addr_o  <= bus.mem_addr_o + AddressWidth'(4);
                    if (byte_idx == '0) begin
                        remaining <= remaining - CountWidth'(1);
                        sector    <= sector + 32'd1;
                    end
                end
                FINISH: busy_o <= 1'b0;
                default: ;
            endcase
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:      next_state = !start_i ? IDLE : (count_i == '0) ? FINISH : ISSUE;
            ISSUE:     next_state = bus.sd_busy_i ? ISSUE : WAIT_READ;
            WAIT_READ: next_state = (!first && !bus.sd_busy_i) ? COLLECT : WAIT_READ;
            COLLECT:   next_state = (byte_idx[1:0] == 2'd3) ? WRITE : COLLECT;
            WRITE:     next_state = !bus.mem_ready_i ? WRITE :
                                    (byte_idx != '0) ? COLLECT :
                                    (remaining == CountWidth'(1)) ? FINISH : ISSUE;
            FINISH:    next_state = IDLE;
            default:   next_state = IDLE;
        endcase
    end

    always_comb begin
        bus.sd_cmd_o    = (state == ISSUE && !bus.sd_busy_i) ? 2'd1 :
                          (state == COLLECT) ? 2'd2 : 2'd0;
        bus.sd_sector_o = sector;
    end
endmodule

// File: tb/tb_sd_sector_loader.sv
// tb_sd_sector_loader: directed bench with a behavioural SD block and RAM write sink.
module tb_sd_sector_loader;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start_i = 1'b0;
    logic [31:0] sector_i = '0;
    logic [15:0] count_i = '0;
    logic [31:0] dest_addr_i = '0;
    logic        busy_o, done_o;

    sd_sector_loader_if #(.AddressWidth(32)) bus ();

    sd_sector_loader #(.AddressWidth(32), .CountWidth(16)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .sector_i(sector_i),
        .count_i(count_i), .dest_addr_i(dest_addr_i), .busy_o(busy_o),
        .done_o(done_o), .bus(bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference SD block: sector byte p of sector s is p + s - 5, so sector 5 holds i&0xFF
    function automatic logic [7:0] sd_byte(input logic [31:0] s, input logic [8:0] p);
        return p[7:0] + s[7:0] - 8'd5;
    endfunction

    function automatic logic [31:0] exp_word(input logic [31:0] s, input int k);
        logic [8:0] p = 9'(4 * k);
        return {sd_byte(s, p + 9'd3), sd_byte(s, p + 9'd2), sd_byte(s, p + 9'd1), sd_byte(s, p)};
    endfunction

    logic [8:0]  ptr = '0;
    logic [31:0] cur_sec = '0;
    int          rd_cnt = 0;
    logic        init_busy = 1'b1;
    int          ready_delay = 0;
    int          vcnt = 0;

    assign bus.sd_busy_i   = init_busy || rd_cnt != 0;
    assign bus.sd_data_i   = sd_byte(cur_sec, ptr);
    assign bus.mem_ready_i = bus.mem_valid_o && vcnt >= ready_delay;

    always @(posedge clk) begin
        if (bus.sd_cmd_o == 2'd1) begin
            cur_sec <= bus.sd_sector_o;
            ptr     <= '0;
            rd_cnt  <= 4;
        end else begin
            if (rd_cnt != 0) rd_cnt <= rd_cnt - 1;
            if (bus.sd_cmd_o == 2'd2) ptr <= ptr + 9'd1;
        end
        vcnt <= (bus.mem_valid_o && !bus.mem_ready_i) ? vcnt + 1 : 0;
    end

    logic [31:0] wa[$], wd[$], sec_log[$];
    int cyc = 0, first_cmd1 = -1, done_cnt = 0, cmd_act = 0, cmd_bad = 0;
    int busy_bad = 0, stab_bad = 0, wr_cmd_bad = 0, stalls = 0;
    logic        prev_pend = 1'b0;
    logic [31:0] pa, pd;

    always @(negedge clk) begin
        cyc++;
        if (bus.mem_valid_o && bus.mem_ready_i) begin
            wa.push_back(bus.mem_addr_o);
            wd.push_back(bus.mem_data_o);
        end
        if (prev_pend && (!bus.mem_valid_o || bus.mem_addr_o !== pa || bus.mem_data_o !== pd))
            stab_bad++;
        prev_pend = rst_n && bus.mem_valid_o && !bus.mem_ready_i;
        pa = bus.mem_addr_o;
        pd = bus.mem_data_o;
        if (bus.mem_valid_o && !bus.mem_ready_i) stalls++;
        if (bus.sd_cmd_o == 2'd1) begin
            sec_log.push_back(bus.sd_sector_o);
            if (first_cmd1 < 0) first_cmd1 = cyc;
        end
        if (bus.sd_cmd_o != 2'd0) cmd_act++;
        if (bus.sd_cmd_o != 2'd0 && bus.sd_busy_i) cmd_bad++;
        if (bus.sd_cmd_o == 2'd2 && bus.mem_valid_o) wr_cmd_bad++;
        if (done_o) begin
            done_cnt++;
            if (busy_o) busy_bad++;
        end
    end

    task automatic run(input logic [31:0] sec, input logic [15:0] cnt, input logic [31:0] dst,
                       output int lat);
        wa.delete();
        wd.delete();
        sec_log.delete();
        done_cnt = 0;
        cmd_act = 0;
        @(negedge clk);
        sector_i = sec;
        count_i = cnt;
        dest_addr_i = dst;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        lat = 1;
        while (!done_o && lat < 20000) begin
            @(negedge clk);
            lat++;
        end
        chk("done_timeout", 32'(done_o), 32'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic verify(input string tag, input logic [31:0] sec, input int cnt,
                          input logic [31:0] dst);
        int errs = 0;
        chk({tag, "_nwr"}, 32'(wa.size()), 32'(cnt * 128));
        for (int i = 0; i < wa.size() && i < cnt * 128; i++)
            if (wa[i] !== (dst & ~32'd3) + 32'(4 * i) || wd[i] !== exp_word(sec + 32'(i / 128), i % 128))
                errs++;
        chk({tag, "_ram"}, 32'(errs), 32'd0);
        chk({tag, "_done"}, 32'(done_cnt), 32'd1);
    endtask

    int lat, fall_cyc, n;

    initial begin
        #3 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_cmd", 32'(bus.sd_cmd_o), 32'd0);
        chk("rst_valid", 32'(bus.mem_valid_o), 32'd0);
        chk("rst_addr", bus.mem_addr_o, 32'd0);
        chk("rst_data", bus.mem_data_o, 32'd0);
        rst_n = 1'b1;
        cyc = 0;
        first_cmd1 = -1;
        busy_bad = 0;
        cmd_bad = 0;

        // card init keeps sd_busy high; start at cycle 10, plus a stray start mid-transfer
        fork
            begin repeat (100) @(negedge clk); init_busy = 1'b0; fall_cyc = cyc; end
            begin repeat (9) @(negedge clk); run(32'd5, 16'd1, 32'h1000, lat); end
            begin
                repeat (400) @(negedge clk);
                sector_i = 32'd77; count_i = 16'd9; start_i = 1'b1;
                @(negedge clk);
                start_i = 1'b0;
            end
        join
        chk("t1_cmd1_after_init", 32'(first_cmd1 > fall_cyc), 32'd1);
        chk("t1_ncmd1", 32'(sec_log.size()), 32'd1);
        chk("t1_sector", sec_log.size() > 0 ? sec_log[0] : 32'hBAD0BAD0, 32'd5);
        chk("t1_first_addr", wa.size() > 0 ? wa[0] : 32'hBAD0BAD0, 32'h1000);
        chk("t1_first_data", wd.size() > 0 ? wd[0] : 32'hBAD0BAD0, 32'h03020100);
        chk("t1_last_addr", wa.size() > 0 ? wa[wa.size() - 1] : 32'hBAD0BAD0, 32'h11FC);
        chk("t1_last_data", wd.size() > 0 ? wd[wd.size() - 1] : 32'hBAD0BAD0, 32'hFFFEFDFC);
        verify("t1", 32'd5, 1, 32'h1000);

        run(32'hFFFF_FFFF, 16'd3, 32'hFFFF_FE00, lat);
        chk("t2_ncmd1", 32'(sec_log.size()), 32'd3);
        for (int i = 0; i < 3; i++)
            chk("t2_sector", i < sec_log.size() ? sec_log[i] : 32'hBAD0BAD0, 32'hFFFF_FFFF + 32'(i));
        verify("t2", 32'hFFFF_FFFF, 3, 32'hFFFF_FE00);

        run(32'd8, 16'd0, 32'h4000, lat);
        chk("t3_latency", 32'(lat), 32'd2);
        chk("t3_cmd_activity", 32'(cmd_act), 32'd0);
        chk("t3_nwr", 32'(wa.size()), 32'd0);
        chk("t3_done", 32'(done_cnt), 32'd1);

        ready_delay = 5;
        stab_bad = 0;
        wr_cmd_bad = 0;
        stalls = 0;
        run(32'd5, 16'd1, 32'h1003, lat);
        ready_delay = 0;
        chk("t4_stable", 32'(stab_bad), 32'd0);
        chk("t4_cmd2_in_write", 32'(wr_cmd_bad), 32'd0);
        chk("t4_stalls", 32'(stalls), 32'd640);
        verify("t4", 32'd5, 1, 32'h1000);

        // abort during Collect of the second sector
        sec_log.delete();
        done_cnt = 0;
        @(negedge clk);
        sector_i = 32'd5; count_i = 16'd2; dest_addr_i = 32'h2000; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        n = 0;
        while (!(sec_log.size() == 2 && bus.sd_cmd_o == 2'd2) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("t6_reach_collect", 32'(bus.sd_cmd_o), 32'd2);
        repeat (37) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_busy", 32'(busy_o), 32'd0);
        chk("t6_cmd", 32'(bus.sd_cmd_o), 32'd0);
        chk("t6_sector", bus.sd_sector_o, 32'd0);
        chk("t6_valid", 32'(bus.mem_valid_o), 32'd0);
        chk("t6_addr", bus.mem_addr_o, 32'd0);
        chk("t6_data", bus.mem_data_o, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        chk("t6_no_done", 32'(done_cnt), 32'd0);
        run(32'd9, 16'd1, 32'h3000, lat);
        verify("t6", 32'd9, 1, 32'h3000);

        chk("busy_with_done", 32'(busy_bad), 32'd0);
        chk("cmd_while_busy", 32'(cmd_bad), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sd_sector_loader.md
Name: sd_sector_loader

Overview:
- Sits directly downstream of the SD card interface block and drives its byte-oriented command port: cmd 1 starts a sector read, cmd 2 advances the byte pointer.
- Copies a run of consecutive 512-byte sectors into word-addressed RAM.
- Bytes are packed little-endian into 32-bit words and written through a valid/ready write port.
- Used by the boot path to load a program image from SD card into PSRAM-backed memory.

Parameters:
- AddressWidth, 32, width of RAM byte address (dest_addr_i, mem_addr_o).
- CountWidth, 16, width of sector count input.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- start_i  in  1  one-cycle request; sampled only in Idle.
- sector_i  in  32  first SD sector number.
- count_i  in  CountWidth  number of sectors to copy.
- dest_addr_i  in  AddressWidth  RAM byte address of first word; bits [1:0] ignored (treated as 0).
- busy_o  out  1  high from accepted start until done.
- done_o  out  1  one-cycle pulse when the transfer completes.
- sd_cmd_o  out  2  to SD block: 0 idle, 1 start read, 2 next byte.
- sd_sector_o  out  32  sector address presented with cmd 1.
- sd_data_i  in  8  byte at the SD block's current buffer pointer (combinational there).
- sd_busy_i  in  1  SD block busy; also high during card init after reset.
- mem_addr_o  out  AddressWidth  word-aligned write address.
- mem_data_o  out  32  write data.
- mem_valid_o  out  1  write request; held until accepted.
- mem_ready_i  in  1  write accepted on a cycle where valid&&ready.

Behaviour:
- Reset values (async): busy_o=0, done_o=0, sd_cmd_o=0, sd_sector_o=0, mem_valid_o=0, mem_addr_o=0, mem_data_o=0; state=Idle; all counters 0.
- States: Idle, Issue, WaitRead, Collect, Write, Finish.
- Idle: on start_i:
  - latch sector_i, count_i, dest_addr_i&~3;
  - busy_o<=1;
  - if count_i==0 go to Finish, else go to Issue.
  - start_i outside Idle is ignored.
- Issue: wait while sd_busy_i==1; this covers card init. When sd_busy_i==0, drive sd_cmd_o=1 and sd_sector_o=current sector for exactly one cycle, then go to WaitRead.
- WaitRead:
  - sd_cmd_o=0.
  - The first cycle in this state ignores sd_busy_i, because the SD block registers busy one cycle after sampling cmd 1.
  - Afterwards, when sd_busy_i==0: byte_idx<=0, go to Collect.
- Collect (one byte per cycle):
  - Capture sd_data_i into word lane byte_idx[1:0] (lane 0 = bits 7:0) and drive sd_cmd_o=2 in the same cycle; the next cycle sees the next byte. byte_idx increments.
  - When lane 3 is captured: load mem_data_o with the full word, assert mem_valid_o, go to Write.
- Write:
  - sd_cmd_o=0; hold mem_valid_o, mem_addr_o, mem_data_o stable until mem_ready_i.
  - On acceptance: mem_valid_o<=0, mem_addr_o+=4.
  - If byte_idx wrapped to 0 (512 bytes done): decrement the remaining count and increment the sector. Then go to Issue if remaining>0, else go to Finish.
  - Otherwise return to Collect.
  - mem_ready_i may already be high in the first Write cycle, giving a 1-cycle write.
- Finish: done_o=1 for one cycle, busy_o<=0, go to Idle.
- Arithmetic and wrap:
  - byte_idx is 9 bits and wraps 511->0, matching the SD block's pointer, which has also returned to 0 after 512 cmd-2 steps.
  - The sector counter wraps modulo 2^32.
  - mem_addr_o wraps modulo 2^AddressWidth with no error.
- sd_cmd_o is never 1 or 2 while sd_busy_i is high, except the single Issue cycle, which is gated on sd_busy_i==0.
- Reset mid-transfer aborts immediately; no done_o pulse. The SD block's reset is independent; after reset the loader re-waits on sd_busy_i.
- Throughput per sector is about 512 + 128×(write latency) cycles, plus SD read time.

Test Plan:
- SD model fills sector 5 with bytes i&0xFF; start sector=5, count=1, dest=0x1000 -> 128 writes. First write is addr 0x1000, data 0x03020100; last write is addr 0x11FC, data 0xFFFEFDFC. done_o pulses once and busy_o falls with it.
- count=3, sector=0xFFFFFFFF -> cmd 1 is issued with sectors 0xFFFFFFFF, 0x00000000, 0x00000001; 384 writes to consecutive addresses.
- count=0 -> done_o pulses 2 cycles after start_i; no sd_cmd_o activity and no memory writes.
- mem_ready_i held low for 5 cycles on every write -> data and address are stable while valid; no cmd 2 is issued during Write; final RAM contents match the count=1 case.
- sd_busy_i held high for 100 cycles after reset (card init); start_i at cycle 10 -> cmd 1 appears only after sd_busy_i falls. start_i pulsed mid-transfer is ignored.
- Assert rst_n low during Collect of sector 1 of 2 -> all outputs reach reset values asynchronously and no done_o pulse occurs; a new start then completes normally.
